// File: rtl/fv_pkg.sv
// Shared FV types: the EX queue entry record and default sizing for the
// fetch/commit interfaces.
package fv_pkg;

   localparam int unsigned FV_EXQ_DEPTH              = 8;
   localparam int unsigned FV_IF_MAX_INSTR_PER_CYCLE = 2;
   localparam int unsigned FV_MAX_COMMIT_PER_CYCLE   = 2;
   localparam int unsigned FV_INSTR_W                = 32;
   localparam int unsigned FV_PC_W                   = 32;

   typedef struct packed {
      logic [FV_INSTR_W-1:0] instr;
      logic [FV_PC_W-1:0]    pc;
      logic [2:0]            instr_size;
      logic                  is_dup;
   } ex_queue_entry_t;

endpackage

// File: rtl/fv_ex_instr_queue_if.sv
// Signal bundle between fetch, the DUT commit/kill monitors and the EX
// instruction tracking queue.
interface fv_ex_instr_queue_if
   import fv_pkg::*;
#(
   parameter int unsigned DEPTH = FV_EXQ_DEPTH,
   parameter int unsigned IN_W  = FV_IF_MAX_INSTR_PER_CYCLE,
   parameter int unsigned CMT_W = FV_MAX_COMMIT_PER_CYCLE
) ();

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic [IN_W:1]             enq_valid;
   ex_queue_entry_t [IN_W:1]  enq_entry;
   logic                      enq_ready;
   logic [CMT_W:1]            commit;
   logic                      kill;
   logic                      is_empty;
   logic                      is_full;
   logic                      no_uncommitted_instr;
   logic [CNT_W-1:0]          count;
   logic [CMT_W:1]            check_committed_instr;
   ex_queue_entry_t [CMT_W:1] committed_entry;
   logic                      received_kill;
   logic                      killed_instr_found;
   ex_queue_entry_t           killed_instr;
   logic                      overflow_err;
   logic                      underflow_err;
   logic                      protocol_err;

   modport master (
      output enq_valid, enq_entry, commit, kill,
      input  enq_ready, is_empty, is_full, no_uncommitted_instr, count,
             check_committed_instr, committed_entry, received_kill,
             killed_instr_found, killed_instr, overflow_err, underflow_err,
             protocol_err
   );

   modport slave (
      input  enq_valid, enq_entry, commit, kill,
      output enq_ready, is_empty, is_full, no_uncommitted_instr, count,
             check_committed_instr, committed_entry, received_kill,
             killed_instr_found, killed_instr, overflow_err, underflow_err,
             protocol_err
   );

endinterface

// File: rtl/fv_slot_compactor.sv
// Packs the valid fetch slots into a dense list (slot 1 oldest) and reports
// how many were valid.
module fv_slot_compactor
   import fv_pkg::*;
#(
   parameter  int unsigned IN_W  = FV_IF_MAX_INSTR_PER_CYCLE,
   localparam int unsigned CNT_W = $clog2(IN_W) + 1
) (
   input  logic [IN_W:1]            valid_i,
   input  ex_queue_entry_t [IN_W:1] entry_i,
   output ex_queue_entry_t [IN_W:1] dense_o,
   output logic [CNT_W-1:0]         cnt_o
);

   // Running count is bumped before the write so it doubles as the 1-based
   // destination slot.
   always_comb begin
      dense_o = '0;
      cnt_o   = '0;
      for (int unsigned i = 1; i <= IN_W; i++) begin
         if (valid_i[i]) begin
            cnt_o          = cnt_o + CNT_W'(1);
            dense_o[cnt_o] = entry_i[i];
         end
      end
   end

endmodule

// File: rtl/fv_ex_instr_queue.sv
// In-order tracking queue between FV fetch and the EX/commit checkers:
// captures fetched instructions, retires them oldest-first, flushes on kill.
module fv_ex_instr_queue
   import fv_pkg::*;
#(
   parameter int unsigned DEPTH = FV_EXQ_DEPTH,
   parameter int unsigned IN_W  = FV_IF_MAX_INSTR_PER_CYCLE,
   parameter int unsigned CMT_W = FV_MAX_COMMIT_PER_CYCLE
) (
   input logic          clk,
   input logic          reset_,
   fv_ex_instr_queue_if.slave q
);

   localparam int unsigned PTR_W     = $clog2(DEPTH);
   localparam int unsigned CNT_W     = PTR_W + 1;
   localparam int unsigned ENQ_CNT_W = $clog2(IN_W) + 1;

   ex_queue_entry_t           mem_q [DEPTH];
   ex_queue_entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]          count_q, count_d;
   logic [CMT_W:1]            cmt_valid_q, cmt_valid_d;
   ex_queue_entry_t [CMT_W:1] cmt_entry_q, cmt_entry_d;
   logic                      rcv_kill_q, rcv_kill_d;
   logic                      kfound_q, kfound_d;
   ex_queue_entry_t           kinstr_q, kinstr_d;
   logic                      ovf_q, ovf_d, unf_q, unf_d, proto_q, proto_d;

   ex_queue_entry_t [IN_W:1]  enq_dense;
   logic [ENQ_CNT_W-1:0]      enq_cnt;
   logic [CNT_W-1:0]          n_req, n_pop, remain;
   logic                      lead_run, thermo_bad;
   logic                      enq_ready, enq_any, underflow;
   logic [PTR_W-1:0]          rd_idx, kill_idx;

   fv_slot_compactor #(.IN_W(IN_W)) u_compactor (
      .valid_i (q.enq_valid),
      .entry_i (q.enq_entry),
      .dense_o (enq_dense),
      .cnt_o   (enq_cnt)
   );

   // Leading-ones count of commit; any set bit after the first zero is a
   // protocol violation but does not add to the retire count.
   always_comb begin
      n_req      = '0;
      lead_run   = 1'b1;
      thermo_bad = 1'b0;
      for (int unsigned k = 1; k <= CMT_W; k++) begin
         if (q.commit[k] && lead_run) begin
            n_req = n_req + CNT_W'(1);
         end else begin
            if (q.commit[k]) thermo_bad = 1'b1;
            lead_run = 1'b0;
         end
      end
   end

   assign underflow = n_req > count_q;
   assign n_pop     = underflow ? count_q : n_req;
   assign remain    = count_q - n_pop;
   assign enq_ready = count_q <= CNT_W'(DEPTH - IN_W);
   assign enq_any   = |q.enq_valid;
   assign kill_idx  = head_q + n_pop[PTR_W-1:0];

   always_comb begin
      mem_d       = mem_q;
      cmt_valid_d = '0;
      cmt_entry_d = '0;
      rd_idx      = head_q;
      for (int unsigned k = 1; k <= CMT_W; k++) begin
         rd_idx         = head_q + PTR_W'(k - 1);
         cmt_valid_d[k] = CNT_W'(k) <= n_pop;
         if (cmt_valid_d[k]) cmt_entry_d[k] = mem_q[rd_idx];
      end

      rcv_kill_d = q.kill;
      kfound_d   = q.kill && (remain != '0);
      kinstr_d   = kfound_d ? mem_q[kill_idx] : '0;

      ovf_d   = ovf_q | (enq_any && !enq_ready);
      unf_d   = unf_q | underflow;
      proto_d = proto_q | thermo_bad;

      // Commits drain first; a kill then discards whatever remains plus
      // this cycle's enqueue, leaving head == tail.
      head_d  = head_q + n_pop[PTR_W-1:0];
      tail_d  = tail_q;
      count_d = remain;
      if (q.kill) begin
         head_d  = tail_q;
         count_d = '0;
      end else if (enq_any && enq_ready) begin
         for (int unsigned j = 1; j <= IN_W; j++) begin
            if (ENQ_CNT_W'(j) <= enq_cnt) mem_d[tail_q + PTR_W'(j - 1)] = enq_dense[j];
         end
         tail_d  = tail_q + PTR_W'(enq_cnt);
         count_d = remain + CNT_W'(enq_cnt);
      end
   end

   always_ff @(posedge clk or posedge reset_) begin
      if (reset_) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         cmt_valid_q <= '0;
         cmt_entry_q <= '0;
         rcv_kill_q  <= 1'b0;
         kfound_q    <= 1'b0;
         kinstr_q    <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         proto_q     <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         cmt_valid_q <= cmt_valid_d;
         cmt_entry_q <= cmt_entry_d;
         rcv_kill_q  <= rcv_kill_d;
         kfound_q    <= kfound_d;
         kinstr_q    <= kinstr_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         proto_q     <= proto_d;
      end
   end

   assign q.enq_ready             = enq_ready;
   assign q.is_empty              = count_q == '0;
   assign q.no_uncommitted_instr  = count_q == '0;
   assign q.is_full               = count_q == CNT_W'(DEPTH);
   assign q.count                 = count_q;
   assign q.check_committed_instr = cmt_valid_q;
   assign q.committed_entry       = cmt_entry_q;
   assign q.received_kill         = rcv_kill_q;
   assign q.killed_instr_found    = kfound_q;
   assign q.killed_instr          = kinstr_q;
   assign q.overflow_err          = ovf_q;
   assign q.underflow_err         = unf_q;
   assign q.protocol_err          = proto_q;

endmodule

// File: tb/tb_fv_ex_instr_queue.sv
// Directed bench for fv_ex_instr_queue with a queue model and a scoreboard
// of expected retirements.
module tb_fv_ex_instr_queue;
   import fv_pkg::*;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned IN_W  = 2;
   localparam int unsigned CMT_W = 2;

   logic clk = 1'b0;
   logic reset_;
   always #5 clk = ~clk;

   fv_ex_instr_queue_if #(.DEPTH(DEPTH), .IN_W(IN_W), .CMT_W(CMT_W)) qif ();

   fv_ex_instr_queue #(.DEPTH(DEPTH), .IN_W(IN_W), .CMT_W(CMT_W)) dut (
      .clk    (clk),
      .reset_ (reset_),
      .q      (qif.slave)
   );

   int checks   = 0;
   int failures = 0;

   ex_queue_entry_t model_q[$];
   ex_queue_entry_t exp_ret[$];
   logic            m_ovf, m_unf, m_pro;

   function automatic ex_queue_entry_t mk(input logic [31:0] pc);
      ex_queue_entry_t e;
      e.instr      = ~pc ^ 32'h5A00_0013;
      e.pc         = pc;
      e.instr_size = pc[4:2];
      e.is_dup     = pc[3];
      return e;
   endfunction

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_count"}, 96'(qif.count), 96'(model_q.size()));
      chk({tag, "_empty"}, 96'(qif.is_empty), 96'(model_q.size() == 0));
      chk({tag, "_nouncmt"}, 96'(qif.no_uncommitted_instr), 96'(model_q.size() == 0));
      chk({tag, "_full"}, 96'(qif.is_full), 96'(model_q.size() == DEPTH));
      chk({tag, "_ready"}, 96'(qif.enq_ready), 96'(model_q.size() + IN_W <= DEPTH));
      chk({tag, "_ovf"}, 96'(qif.overflow_err), 96'(m_ovf));
      chk({tag, "_unf"}, 96'(qif.underflow_err), 96'(m_unf));
      chk({tag, "_proto"}, 96'(qif.protocol_err), 96'(m_pro));
   endtask

   // One clock: drive at negedge, update the model from pre-edge state,
   // then check registered outputs just after the rising edge.
   task automatic step(input string tag, input logic [2:1] v, input logic [31:0] pc1,
                       input logic [31:0] pc2, input logic [2:1] cm, input logic k);
      int              sz0, n, npop;
      logic            ready, bad;
      logic [2:1]      exp_mask;
      logic            exp_kf;
      ex_queue_entry_t exp_ki, e;
      @(negedge clk);
      qif.enq_valid    = v;
      qif.enq_entry[1] = mk(pc1);
      qif.enq_entry[2] = mk(pc2);
      qif.commit       = cm;
      qif.kill         = k;

      sz0   = model_q.size();
      ready = (DEPTH - sz0) >= IN_W;
      bad   = !(cm inside {2'b00, 2'b01, 2'b11});
      n     = cm[1] ? (cm[2] ? 2 : 1) : 0;
      if (bad) m_pro = 1'b1;
      if (n > sz0) m_unf = 1'b1;
      npop     = (n > sz0) ? sz0 : n;
      exp_mask = '0;
      for (int i = 0; i < npop; i++) begin
         exp_ret.push_back(model_q.pop_front());
         exp_mask[i + 1] = 1'b1;
      end
      if (v != '0 && !ready) m_ovf = 1'b1;
      exp_kf = 1'b0;
      exp_ki = '0;
      if (k) begin
         if (model_q.size() > 0) begin
            exp_kf = 1'b1;
            exp_ki = model_q[0];
         end
         model_q.delete();
      end else if (v != '0 && ready) begin
         if (v[1]) model_q.push_back(mk(pc1));
         if (v[2]) model_q.push_back(mk(pc2));
      end

      @(posedge clk);
      #1;
      chk({tag, "_cmtmask"}, 96'(qif.check_committed_instr), 96'(exp_mask));
      for (int s = 1; s <= 2; s++) begin
         if (exp_mask[s]) begin
            e = exp_ret.pop_front();
            chk($sformatf("%s_ret%0d", tag, s), 96'(qif.committed_entry[s]), 96'(e));
         end
      end
      chk({tag, "_rkill"}, 96'(qif.received_kill), 96'(k));
      chk({tag, "_kfound"}, 96'(qif.killed_instr_found), 96'(exp_kf));
      chk({tag, "_kinstr"}, 96'(qif.killed_instr), 96'(exp_ki));
      check_state(tag);
      qif.enq_valid = '0;
      qif.commit    = '0;
      qif.kill      = 1'b0;
   endtask

   task automatic clear_model();
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_pro = 1'b0;
   endtask

   // Reset asserted between edges; outputs must clear without a clock.
   task automatic mid_reset(input string tag);
      @(negedge clk);
      reset_ = 1'b1;
      clear_model();
      #1;
      chk({tag, "_cmtmask"}, 96'(qif.check_committed_instr), 96'(0));
      chk({tag, "_rkill"}, 96'(qif.received_kill), 96'(0));
      chk({tag, "_kfound"}, 96'(qif.killed_instr_found), 96'(0));
      check_state(tag);
      @(negedge clk);
      reset_ = 1'b0;
   endtask

   initial begin
      reset_        = 1'b1;
      qif.enq_valid = '0;
      qif.enq_entry = '0;
      qif.commit    = '0;
      qif.kill      = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      check_state("rst");
      chk("rst_cmtmask", 96'(qif.check_committed_instr), 96'(0));
      @(negedge clk);
      reset_ = 1'b0;

      step("t1_enq", 2'b11, 32'h100, 32'h104, 2'b00, 1'b0);
      step("t1_cmt", 2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
      step("t1_drain", 2'b00, 32'h0, 32'h0, 2'b01, 1'b0);

      step("t2_enq", 2'b10, 32'hDEAD0, 32'h200, 2'b00, 1'b0);
      step("t2_cmt", 2'b00, 32'h0, 32'h0, 2'b01, 1'b0);

      for (int i = 0; i < 4; i++)
         step($sformatf("t3_fill%0d", i), 2'b11, 32'h300 + 32'(i * 8), 32'h304 + 32'(i * 8), 2'b00, 1'b0);
      step("t3_ovf", 2'b11, 32'h3F0, 32'h3F4, 2'b00, 1'b0);
      for (int i = 0; i < 4; i++)
         step($sformatf("t3_drain%0d", i), 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);

      step("t4_enqAB", 2'b11, 32'h400, 32'h404, 2'b00, 1'b0);
      step("t4_enqC", 2'b01, 32'h408, 32'h0, 2'b00, 1'b0);
      step("t4_kill", 2'b11, 32'h500, 32'h504, 2'b01, 1'b1);

      step("t5_enq", 2'b01, 32'h600, 32'h0, 2'b00, 1'b0);
      step("t5_unf", 2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
      step("t5_enq2", 2'b11, 32'h700, 32'h704, 2'b00, 1'b0);
      step("t5_proto", 2'b00, 32'h0, 32'h0, 2'b10, 1'b0);

      step("t6_enq", 2'b11, 32'h800, 32'h804, 2'b00, 1'b0);
      mid_reset("t6_rst");
      step("t6_samecyc", 2'b01, 32'h900, 32'h0, 2'b01, 1'b0);
      step("t6_ret900", 2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
      step("t6_killempty", 2'b00, 32'h0, 32'h0, 2'b00, 1'b1);
      step("t6_idle", 2'b00, 32'h0, 32'h0, 2'b00, 1'b0);

      chk("sb_leftover", 96'(exp_ret.size()), 96'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
